// File: rtl/sc_transi_pkg.sv
// sc_transi shared definitions: state encoding,
// widths shared with the NADA/TRANSI mux, step timing.
package sc_transi_pkg;

  localparam int SC_TRANSI_DATAWIDTH   = 8;
  localparam int SC_TRANSI_SELECTWIDTH = 1;
  localparam int SC_TRANSI_STEP_50MHZ  = 25000000;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_FILL_ENC  = 2'd1;
  localparam logic [1:0] ST_CLEAR_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_FILL  = ST_FILL_ENC,
    ST_CLEAR = ST_CLEAR_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/sc_transi_prescaler.sv
// Clear-able step counter; o_tc strobes on the
// last cycle of each CYCLES-long step while enabled.
module sc_transi_prescaler #(
  parameter int CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = i_en && (r_cnt == LAST);
  assign o_tc = w_tc;

  // count within a step, wrap on terminal count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_transi_sequencer.sv
// Fill-then-clear wipe generator driving the
// TRANSI leg of the row mux, with select/busy/done.
module sc_transi_sequencer
  import sc_transi_pkg::*;
#(
  parameter int TRANSI_DATAWIDTH   = SC_TRANSI_DATAWIDTH,
  parameter int TRANSI_SELECTWIDTH = SC_TRANSI_SELECTWIDTH,
  parameter int TRANSI_STEPCYCLES  = SC_TRANSI_STEP_50MHZ,
  parameter int TRANSI_REPEAT      = 1
) (
  input  logic                          SC_TRANSI_CLOCK_50,
  input  logic                          SC_TRANSI_RESET_InHigh,
  input  logic                          SC_TRANSI_start_InHigh,
  input  logic                          SC_TRANSI_abort_InHigh,
  output logic [TRANSI_DATAWIDTH-1:0]   SC_TRANSI_data_OutBUS,
  output logic [TRANSI_SELECTWIDTH-1:0] SC_TRANSI_select_OutBUS,
  output logic                          SC_TRANSI_busy_Out,
  output logic                          SC_TRANSI_done_Out
);

  localparam int W  = TRANSI_DATAWIDTH;
  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (TRANSI_REPEAT > 1) ?
                      $clog2(TRANSI_REPEAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(TRANSI_REPEAT - 1);

  state_t        r_state;
  state_t        w_state_n;
  logic [KW-1:0] r_k;
  logic [KW-1:0] w_k_n;
  logic [RW-1:0] r_r;
  logic [RW-1:0] w_r_n;
  logic [W-1:0]  r_data;
  logic [W-1:0]  w_data_n;
  logic          r_busy;
  logic          w_busy_n;
  logic          r_done;
  logic          w_done_n;
  logic          w_run;
  logic          w_tc;
  logic [W-1:0]  w_ones;

  assign w_ones = '1;
  assign w_run  = (r_state == ST_FILL) ||
                  (r_state == ST_CLEAR);

  sc_transi_prescaler #(
    .CYCLES (TRANSI_STEPCYCLES)
  ) u_pre (
    .i_clk (SC_TRANSI_CLOCK_50),
    .i_rst (SC_TRANSI_RESET_InHigh),
    .i_clr (!w_run),
    .i_en  (w_run),
    .o_tc  (w_tc)
  );

  // state, counters and registered outputs
  always_ff @(posedge SC_TRANSI_CLOCK_50) begin
    if (SC_TRANSI_RESET_InHigh) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_r     <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_k     <= w_k_n;
      r_r     <= w_r_n;
      r_data  <= w_data_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  // next state and next output values (abort beats strobe)
  always_comb begin
    w_state_n = r_state;
    w_k_n     = r_k;
    w_r_n     = r_r;
    unique case (r_state)
      ST_IDLE: begin
        if (SC_TRANSI_start_InHigh &&
            !SC_TRANSI_abort_InHigh) begin
          w_state_n = ST_FILL;
          w_k_n     = '0;
          w_r_n     = '0;
        end
      end
      ST_FILL: begin
        if (SC_TRANSI_abort_InHigh) begin
          w_state_n = ST_DONE;
        end else if (w_tc) begin
          if (r_k == K_LAST) begin
            w_state_n = ST_CLEAR;
            w_k_n     = '0;
          end else begin
            w_k_n = r_k + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (SC_TRANSI_abort_InHigh) begin
          w_state_n = ST_DONE;
        end else if (w_tc) begin
          if (r_k != K_LAST) begin
            w_k_n = r_k + 1'b1;
          end else if (r_r == R_LAST) begin
            w_state_n = ST_DONE;
          end else begin
            w_state_n = ST_FILL;
            w_k_n     = '0;
            w_r_n     = r_r + 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    w_busy_n = (w_state_n == ST_FILL) ||
               (w_state_n == ST_CLEAR);
    w_done_n = (w_state_n == ST_DONE);
    w_data_n = '0;
    if (w_state_n == ST_FILL) begin
      w_data_n = w_ones >> (W - 1 - int'(w_k_n));
    end else if (w_state_n == ST_CLEAR) begin
      w_data_n = w_ones << (int'(w_k_n) + 1);
    end
  end

  assign SC_TRANSI_data_OutBUS   = r_data;
  assign SC_TRANSI_select_OutBUS = {TRANSI_SELECTWIDTH{r_busy}};
  assign SC_TRANSI_busy_Out      = r_busy;
  assign SC_TRANSI_done_Out      = r_done;

endmodule

// File: doc/sc_transi_sequencer.md
Name: sc_transi_sequencer

Overview:
- Generates the 8-bit "transition" row pattern (a fill-then-clear wipe) and the matching select line for the downstream NADA/TRANSI output mux.
- A start pulse from game control launches the animation. While it runs, select=1 routes the pattern to the matrix row bus.
- On completion, select returns to 0 and a one-cycle done pulse is issued.

Parameters:
- TRANSI_DATAWIDTH, 8: pattern width; equals the mux data width.
- TRANSI_SELECTWIDTH, 1: width of the select output bus.
- TRANSI_STEPCYCLES, 25000000: clocks each pattern value is held (0.5 s at 50 MHz); must be ≥1.
- TRANSI_REPEAT, 1: number of full fill+clear sweeps per start; must be ≥1.

Ports:
- SC_TRANSI_CLOCK_50  in  1  system clock; all state updates on its rising edge.
- SC_TRANSI_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_TRANSI_start_InHigh  in  1  start request; sampled every cycle, 1-cycle pulse expected.
- SC_TRANSI_abort_InHigh  in  1  abort the running animation.
- SC_TRANSI_data_OutBUS  out  TRANSI_DATAWIDTH  pattern row; feeds the mux TRANSI input.
- SC_TRANSI_select_OutBUS  out  TRANSI_SELECTWIDTH  mux select; 1 = TRANSI, 0 = NADA.
- SC_TRANSI_busy_Out  out  1  high while the animation runs.
- SC_TRANSI_done_Out  out  1  one-cycle completion pulse.

Behaviour:
- Single clock domain. Reset is synchronous and active-high, and takes priority over every other input.
- All outputs are registered (Moore); no combinational input-to-output path.
- Reset state: IDLE, data=0, select=0, busy=0, done=0, prescaler=0, step k=0, repeat count r=0.
- States: IDLE, FILL, CLEAR, DONE. W = TRANSI_DATAWIDTH.
- Prescaler: counts 0..STEPCYCLES-1 while in FILL/CLEAR. The step strobe fires when it equals STEPCYCLES-1, then it wraps to 0. It is cleared on entry to FILL.
- IDLE:
  - start=1 and abort=0 → FILL next cycle with k=0, r=0, data=1, select=1, busy=1.
  - abort=1 in IDLE → stay in IDLE; no done pulse.
- FILL: data = (2^(k+1))-1, i.e. bits 0..k set.
  - Strobe with k<W-1 → k++.
  - Strobe with k=W-1 → CLEAR, k=0.
- CLEAR: data = all-ones shifted left by (k+1), truncated to W bits (0xFE, 0xFC … 0x00).
  - Strobe with k<W-1 → k++.
  - Strobe with k=W-1 and r<REPEAT-1 → FILL, k=0, r++, data=1.
  - Strobe with k=W-1 and r=REPEAT-1 → DONE.
- DONE: lasts exactly 1 cycle with data=0, select=0, busy=0, done=1, then goes to IDLE.
- Timing:
  - Each pattern value is visible for exactly STEPCYCLES clocks.
  - First value appears the cycle after start is sampled.
  - Busy lasts 2·W·STEPCYCLES·REPEAT cycles.
  - Done is asserted in the cycle right after the last busy cycle.
- start while busy: ignored; no restart and no timing disturbance.
- abort while in FILL/CLEAR: next cycle enters DONE (done pulse issued). Abort beats a same-cycle strobe.
- select is always equal to busy, replicated across TRANSI_SELECTWIDTH bits.
- data=0 whenever busy=0.
- Counter widths: prescaler uses $clog2(STEPCYCLES) bits (minimum 1); k uses $clog2(W) bits; r uses $clog2(REPEAT) bits (minimum 1). No overflow is possible by construction.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE/FILL/CLEAR/DONE);
  - default width constants shared with the mux (DATAWIDTH=8, SELECTWIDTH=1);
  - the 50 MHz-derived step constant.
- One sub-module: sc_transi_prescaler, a parameterised clear-able counter with a terminal-count strobe output.

Test Plan (W=8, STEPCYCLES=4, REPEAT=1 unless stated; cycle 0 = cycle start is sampled):
- Reset held 3 cycles with random start/abort → data=0x00, select=0, busy=0, done=0 throughout and the cycle after release.
- Start pulse at cycle 0 → data 0x01 on cycles 1-4, 0x03 on cycles 5-8 … 0xFF on 29-32, 0xFE on 33-36 … 0x00 on 61-64; select=busy=1 on cycles 1-64; done=1 on cycle 65 only; IDLE at cycle 66.
- Second start pulse at cycle 10 → waveform identical to the previous scenario, done still at cycle 65.
- Abort at cycle 20 → cycle 21: done=1, select=0, data=0x00; cycle 22: IDLE; new start at cycle 23 gives data=0x01 on cycle 24.
- Reset asserted at cycle 30 → cycle 31: all outputs 0 and no done pulse; start at cycle 33 gives the full sequence.
- REPEAT=2 → second sweep begins with 0x01 on cycle 65; done=1 on cycle 129. STEPCYCLES=1 → a new value every clock, done on cycle 17.
